letreiro_scroll_ctrl: RTL and testbench

- Sequencer for the letter marquee: scrolls the fixed message "GABRIEL" plus three blanks across four 7-segment digits.
- Drives one 3-bit letter code per digit into four instances of the existing 3-bit letter decoder.
- A prescaler sets scroll speed. Start, stop, pause, single-step and direction come from board buttons/switches, already debounced upstream.

---
 rtl/letreiro_scroll_ctrl.sv | 131 +++++++++++++
 tb/tb_letreiro_scroll_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/letreiro_scroll_ctrl.sv
// Scroll sequencer for the GABRIEL marquee.
// Feeds four 3-bit letter codes to the 7-segment letter decoders.
module letreiro_scroll_ctrl #(
  parameter int DIV = 50_000_000,
  parameter int CW  = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        step,
  input  logic        dir,
  output logic [11:0] digits,
  output logic [3:0]  pos,
  output logic        wrap,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    PAUSE
  } state_t;

  localparam logic [CW-1:0] LAST   = CW'(DIV - 1);
  localparam logic [11:0]   BLANKS = 12'hDB6;

  state_t        state, state_n;
  logic [CW-1:0] presc, presc_n;
  logic [3:0]    pos_n;
  logic [11:0]   digits_n;
  logic          wrap_n;
  logic          adv;

  function automatic logic [2:0] rom(input logic [3:0] i);
    logic [2:0] c;
    case (i)
      4'd0:    c = 3'b111;
      4'd1:    c = 3'b000;
      4'd2:    c = 3'b001;
      4'd3:    c = 3'b010;
      4'd4:    c = 3'b011;
      4'd5:    c = 3'b100;
      4'd6:    c = 3'b101;
      default: c = 3'b110;
    endcase
    return c;
  endfunction

  function automatic logic [11:0] window(input logic [3:0] p);
    logic [11:0] w;
    logic [3:0]  idx;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 4'(k);
      if (idx >= 4'd10) idx = idx - 4'd10;
      w[(3-k)*3 +: 3] = rom(idx);
    end
    return w;
  endfunction

  // Next state, prescaler, position and the display image for the next cycle
  always_comb begin
    state_n = state;
    presc_n = presc;
    pos_n   = pos;
    adv     = 1'b0;
    wrap_n  = 1'b0;
    if (stop) begin
      state_n = IDLE;
      presc_n = '0;
      pos_n   = 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n = SCROLL;
            presc_n = '0;
            pos_n   = 4'd0;
          end
        end
        SCROLL: begin
          if (pause) begin
            state_n = PAUSE;
          end else if (presc == LAST) begin
            presc_n = '0;
            adv     = 1'b1;
          end else begin
            presc_n = presc + CW'(1);
          end
        end
        PAUSE: begin
          adv = step;
          if (!pause) state_n = SCROLL;
        end
        default: state_n = IDLE;
      endcase
    end
    if (adv) begin
      if (dir) begin
        pos_n  = (pos == 4'd0) ? 4'd9 : pos - 4'd1;
        wrap_n = (pos == 4'd0);
      end else begin
        pos_n  = (pos == 4'd9) ? 4'd0 : pos + 4'd1;
        wrap_n = (pos == 4'd9);
      end
    end
    digits_n = (state_n == IDLE) ? BLANKS : window(pos_n);
  end

  // Register state and every output on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      presc  <= '0;
      pos    <= 4'd0;
      digits <= BLANKS;
      wrap   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      pos    <= pos_n;
      digits <= digits_n;
      wrap   <= wrap_n;
      busy   <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_letreiro_scroll_ctrl.sv
// Bench for the marquee scroll sequencer.
// Message-level model plus directed literal checks.
module tb_letreiro_scroll_ctrl;

  localparam int DIV = 4;
  localparam int CW  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        step = 1'b0;
  logic        dir = 1'b0;
  logic [11:0] digits;
  logic [3:0]  pos;
  logic        wrap;
  logic        busy;

  int total = 0;
  int bad = 0;

  string msg = "GABRIEL   ";
  int    m_mode = 0;
  int    m_pos = 0;
  int    m_cnt = 0;
  bit    m_wrap = 1'b0;
  bit    armed = 1'b0;

  letreiro_scroll_ctrl #(.DIV(DIV), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .pause(pause),
    .step(step),
    .dir(dir),
    .digits(digits),
    .pos(pos),
    .wrap(wrap),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] code(input byte c);
    logic [2:0] r;
    case (c)
      "A":     r = 3'b000;
      "B":     r = 3'b001;
      "R":     r = 3'b010;
      "I":     r = 3'b011;
      "E":     r = 3'b100;
      "L":     r = 3'b101;
      "G":     r = 3'b111;
      default: r = 3'b110;
    endcase
    return r;
  endfunction

  function automatic logic [11:0] view(input int p);
    logic [11:0] v;
    v = '0;
    for (int k = 0; k < 4; k++)
      v = (v << 3) | 12'(code(msg[(p + k) % 10]));
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Message-level model advanced on each edge, then compared to the DUT
  always @(posedge clk) begin : model
    bit adv;
    int old;
    adv = 1'b0;
    if (!rst_n || stop) begin
      m_mode = 0;
      m_pos  = 0;
      m_cnt  = 0;
      m_wrap = 1'b0;
      if (!rst_n) armed = 1'b1;
    end else begin
      m_wrap = 1'b0;
      case (m_mode)
        0: if (start) begin
          m_mode = 1;
          m_pos  = 0;
          m_cnt  = 0;
        end
        1: begin
          if (pause) m_mode = 2;
          else if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            adv = 1'b1;
          end else m_cnt++;
        end
        default: begin
          adv = step;
          if (!pause) m_mode = 1;
        end
      endcase
      if (adv) begin
        old = m_pos;
        m_pos = dir ? (m_pos + 9) % 10 : (m_pos + 1) % 10;
        m_wrap = dir ? (old == 0) : (old == 9);
      end
    end
    #1;
    if (armed) begin
      check("m_digits", digits, (m_mode == 0) ? 12'hDB6 : view(m_pos));
      check("m_pos", pos, m_pos);
      check("m_wrap", wrap, m_wrap);
      check("m_busy", busy, m_mode != 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int t);
    int n;
    n = 0;
    while (pos !== 4'(t) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("wait_pos", pos, t);
  endtask

  initial begin
    int n;
    // reset, start held high
    rst_n = 1'b0;
    start = 1'b1;
    cyc(3);
    check("rst_digits", digits, 12'hDB6);
    check("rst_pos", pos, 0);
    check("rst_busy", busy, 0);
    check("rst_wrap", wrap, 0);
    start = 1'b0;
    rst_n = 1'b1;
    cyc(1);
    check("idle_digits", digits, 12'hDB6);

    // start pulse
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("start_digits", digits, 12'hE0A);
    check("start_busy", busy, 1);
    cyc(4);
    check("tick1_pos", pos, 1);
    check("tick1_digits", digits, 12'h053);

    // run left to 9, then wrap
    wait_pos(9);
    check("pos9_digits", digits, 12'hDC1);
    check("pos9_wrap", wrap, 0);
    n = 0;
    while (wrap !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("wrap90", wrap, 1);
    check("wrap90_pos", pos, 0);
    check("wrap90_digits", digits, 12'hE0A);
    cyc(1);
    check("wrap90_pulse", wrap, 0);

    // run right across 0
    dir = 1'b1;
    wait_pos(9);
    check("wrap09", wrap, 1);
    wait_pos(8);
    check("pos8_wrap", wrap, 0);

    // pause on the tick cycle, step, resume
    cyc(3);
    pause = 1'b1;
    cyc(1);
    check("pause_pos", pos, 8);
    check("pause_busy", busy, 1);
    step = 1'b1;
    dir = 1'b0;
    cyc(1);
    step = 1'b0;
    check("step_pos", pos, 9);
    check("step_wrap", wrap, 0);
    cyc(2);
    check("hold_pos", pos, 9);
    pause = 1'b0;
    cyc(1);
    check("resume_pos", pos, 9);
    cyc(1);
    check("resume_tick", pos, 0);
    check("resume_wrap", wrap, 1);

    // stop mid-scroll, restart, stop+start in idle
    wait_pos(5);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("stop_digits", digits, 12'hDB6);
    check("stop_pos", pos, 0);
    check("stop_busy", busy, 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("restart_digits", digits, 12'hE0A);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("stop2_busy", busy, 0);
    start = 1'b1;
    stop = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    check("stopstart_busy", busy, 0);
    check("stopstart_digits", digits, 12'hDB6);

    // mixed control traffic, model-checked
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      step  = ($urandom_range(0, 2) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    start = 1'b0;
    stop = 1'b0;
    step = 1'b0;
    pause = 1'b0;

    // reset mid-run beats start
    rst_n = 1'b0;
    start = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    start = 1'b0;
    check("rst2_digits", digits, 12'hDB6);
    check("rst2_busy", busy, 0);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
